lc3_pipe_controller: RTL and testbench

Pipeline sequencer for the LC-3 CPU. It drives the per-stage enables, the branch-taken strobe, the ALU/memory operand bypass selects and the data-memory access state that the controller_out agent monitors. It sits between the decode/execute datapath (the IR, IR_Exec, NZP and psr taps) and the fetch, decode, execute, writeback and memaccess stages. It owns pipeline fill after reset, memory-access stalls, control-flow bubbles and forwarding decisions.

---
 rtl/lc3_ctrl_pkg.sv | 53 +++++
 rtl/lc3_bypass_unit.sv | 50 +++++
 rtl/lc3_pipe_controller.sv | 155 +++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcodes, state
// encodings and opcode class checks used by the controller and bypass unit.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MEM_RD   = 2'b00,
    MEM_IND  = 2'b01,
    MEM_WR   = 2'b10,
    MEM_IDLE = 2'b11
  } mem_state_t;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    MEM
  } ctrl_state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  // Instructions whose IR[8:6] names a register operand that can be forwarded.
  function automatic logic uses_sr1(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
           (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_bypass_unit.sv
// Combinational operand-forwarding decisions for the instruction in decode
// against the instruction in execute (ALU result or freshly loaded data).
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic        enable_decode,
  input  logic        mem_return,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic [3:0] op_d;
  logic [3:0] op_x;
  logic [2:0] sr1;
  logic [2:0] sr2;
  logic [2:0] dr;
  logic       src1_ok;
  logic       src2_ok;
  logic       hit_1;
  logic       hit_2;
  logic       load_ret;
  logic       unused_bits;

  assign op_d = ir[15:12];
  assign op_x = ir_exec[15:12];
  assign sr1  = ir[8:6];
  assign sr2  = ir[2:0];
  assign dr   = ir_exec[11:9];

  assign src1_ok = enable_decode && uses_sr1(op_d);
  assign src2_ok = enable_decode && ((op_d == OP_ADD) || (op_d == OP_AND)) && !ir[5];

  assign hit_1 = src1_ok && (dr == sr1);
  assign hit_2 = src2_ok && (dr == sr2);

  // Loaded data only exists to forward in the cycle the access completes.
  assign load_ret = mem_return && is_load(op_x);

  assign bypass_mem_1 = hit_1 && load_ret;
  assign bypass_mem_2 = hit_2 && load_ret;
  assign bypass_alu_1 = hit_1 && is_alu(op_x) && !bypass_mem_1;
  assign bypass_alu_2 = hit_2 && is_alu(op_x) && !bypass_mem_2;

  assign unused_bits = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: fill after reset, data-memory stalls, branch
// bubbles, branch-taken strobe and operand bypass selects.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int BR_BUBBLES = 3
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] IMem_dout,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  localparam int CW = (BR_BUBBLES < 2) ? 1 : $clog2(BR_BUBBLES + 1);

  ctrl_state_t state;
  mem_state_t  mem_q;
  logic [1:0]  fill_cnt;
  logic [CW-1:0] bub_cnt;
  logic [CW-1:0] bub_run_next;
  logic        mem_is_load;
  logic        mem_return;
  logic [3:0]  op_d;
  logic [3:0]  op_x;
  logic        start_bubble;
  logic        take_mem;
  mem_state_t  mem_entry;
  logic        unused_inputs;

  assign op_d = IR[15:12];
  assign op_x = IR_Exec[15:12];
  assign mem_state = mem_q;
  assign unused_inputs = ^IMem_dout;

  assign start_bubble = is_ctrl(op_d) && enable_decode;

  // The instruction that just finished its access is still in execute on
  // the return cycle and must not start a second access.
  assign take_mem = (is_load(op_x) || is_store(op_x)) && enable_execute && !mem_return;

  always_comb begin
    bub_run_next = bub_cnt;
    if (start_bubble)
      bub_run_next = CW'(BR_BUBBLES);
    else if (bub_cnt != '0)
      bub_run_next = bub_cnt - CW'(1);
  end

  always_comb begin
    mem_entry = MEM_WR;
    if ((op_x == OP_LDI) || (op_x == OP_STI))
      mem_entry = MEM_IND;
    else if (is_load(op_x))
      mem_entry = MEM_RD;
  end

  assign br_taken = enable_execute &&
                    ((op_x == OP_JMP) || ((op_x == OP_BR) && ((NZP & psr) != 3'b000)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= FILL;
      mem_q            <= MEM_IDLE;
      fill_cnt         <= 2'd0;
      bub_cnt          <= '0;
      mem_is_load      <= 1'b0;
      mem_return       <= 1'b0;
      enable_updatePC  <= 1'b0;
      enable_fetch     <= 1'b0;
      enable_decode    <= 1'b0;
      enable_execute   <= 1'b0;
      enable_writeback <= 1'b0;
    end else begin
      mem_return <= 1'b0;
      case (state)
        FILL: begin
          fill_cnt         <= fill_cnt + 2'd1;
          enable_updatePC  <= 1'b1;
          enable_fetch     <= 1'b1;
          enable_decode    <= (fill_cnt >= 2'd1);
          enable_execute   <= (fill_cnt >= 2'd2);
          enable_writeback <= (fill_cnt == 2'd3);
          if (fill_cnt == 2'd3)
            state <= RUN;
        end
        RUN: begin
          bub_cnt <= bub_run_next;
          if (take_mem) begin
            state            <= MEM;
            mem_q            <= mem_entry;
            mem_is_load      <= is_load(op_x);
            enable_updatePC  <= 1'b0;
            enable_fetch     <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
          end else begin
            enable_updatePC  <= (bub_run_next == '0) && complete_instr;
            enable_fetch     <= (bub_run_next == '0) && complete_instr;
            enable_decode    <= (bub_run_next == '0) && complete_instr;
            enable_execute   <= 1'b1;
            enable_writeback <= 1'b1;
          end
        end
        MEM: begin
          // Bubble counter is intentionally left untouched while stalled.
          if (complete_data) begin
            if (mem_q == MEM_IND) begin
              mem_q <= mem_is_load ? MEM_RD : MEM_WR;
            end else begin
              state            <= RUN;
              mem_q            <= MEM_IDLE;
              mem_return       <= 1'b1;
              enable_updatePC  <= (bub_cnt == '0);
              enable_fetch     <= (bub_cnt == '0);
              enable_decode    <= (bub_cnt == '0);
              enable_execute   <= 1'b1;
              enable_writeback <= mem_is_load;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  lc3_bypass_unit u_bypass (
    .ir            (IR),
    .ir_exec       (IR_Exec),
    .enable_decode (enable_decode),
    .mem_return    (mem_return),
    .bypass_alu_1  (bypass_alu_1),
    .bypass_alu_2  (bypass_alu_2),
    .bypass_mem_1  (bypass_mem_1),
    .bypass_mem_2  (bypass_mem_2)
  );

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Scoreboard bench for lc3_pipe_controller: a behavioural model predicts every
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_lc3_pipe_controller;

  localparam int BUBBLES = 3;
  localparam logic [15:0] NOP_D = 16'h1020;
  localparam logic [15:0] NOP_X = 16'hEE00;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [15:0] IMem_dout;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  lc3_pipe_controller #(.BR_BUBBLES(BUBBLES)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .IMem_dout        (IMem_dout),
    .NZP              (NZP),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state, advanced once per rising edge.
  int         since_release;
  bit         in_mem;
  logic [1:0] mem_steps[$];
  int         bubbles;
  bit         just_returned;
  bit         wb_after_mem;
  bit         m_upc, m_fetch, m_dec, m_exe, m_wb;
  logic [1:0] m_ms;

  logic        c_rst, c_ci, c_cd;
  logic [15:0] c_ir, c_irx;
  logic [2:0]  c_psr;

  logic [11:0] exp_q[$];
  int checks;
  int failures;
  int cycle;

  function bit op_is_load(input logic [3:0] op);
    return op inside {4'b0010, 4'b0110, 4'b1010};
  endfunction

  function bit op_is_store(input logic [3:0] op);
    return op inside {4'b0011, 4'b0111, 4'b1011};
  endfunction

  function bit op_is_alu(input logic [3:0] op);
    return op inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
  endfunction

  function void model_reset();
    since_release = 0;
    in_mem        = 1'b0;
    mem_steps.delete();
    bubbles       = 0;
    just_returned = 1'b0;
    wb_after_mem  = 1'b0;
    {m_upc, m_fetch, m_dec, m_exe, m_wb} = 5'b00000;
    m_ms = 2'b11;
  endfunction

  function void model_step();
    bit ret_now;
    logic [3:0] opd;
    logic [3:0] opx;
    bit front;
    opd = c_ir[15:12];
    opx = c_irx[15:12];
    if (!c_rst) begin
      model_reset();
    end else if (since_release < 4) begin
      since_release++;
      m_upc = 1'b1;
      m_fetch = 1'b1;
      m_dec = (since_release >= 2);
      m_exe = (since_release >= 3);
      m_wb  = (since_release >= 4);
      just_returned = 1'b0;
    end else if (in_mem) begin
      just_returned = 1'b0;
      if (c_cd) begin
        void'(mem_steps.pop_front());
        if (mem_steps.size() == 0) begin
          in_mem = 1'b0;
          just_returned = 1'b1;
          m_ms = 2'b11;
          front = (bubbles == 0);
          {m_upc, m_fetch, m_dec} = {front, front, front};
          m_exe = 1'b1;
          m_wb = wb_after_mem;
        end else begin
          m_ms = mem_steps[0];
        end
      end
    end else begin
      ret_now = just_returned;
      just_returned = 1'b0;
      if ((opd == 4'b0000 || opd == 4'b1100) && m_dec)
        bubbles = BUBBLES;
      else if (bubbles > 0)
        bubbles--;
      if ((op_is_load(opx) || op_is_store(opx)) && m_exe && !ret_now) begin
        in_mem = 1'b1;
        mem_steps.delete();
        if (opx == 4'b1010 || opx == 4'b1011) mem_steps.push_back(2'b01);
        mem_steps.push_back(op_is_load(opx) ? 2'b00 : 2'b10);
        wb_after_mem = op_is_load(opx);
        m_ms = mem_steps[0];
        {m_upc, m_fetch, m_dec, m_exe, m_wb} = 5'b00000;
      end else begin
        front = (bubbles == 0) && c_ci;
        {m_upc, m_fetch, m_dec} = {front, front, front};
        m_exe = 1'b1;
        m_wb = 1'b1;
      end
    end
  endfunction

  function logic [11:0] expected_now();
    logic [3:0] opd, opx;
    logic [2:0] dr;
    bit br, s1, s2, a1, a2, mm1, mm2;
    opd = c_ir[15:12];
    opx = c_irx[15:12];
    dr  = c_irx[11:9];
    br  = m_exe && (opx == 4'b1100 || (opx == 4'b0000 && (c_irx[11:9] & c_psr) != 3'b000));
    s1  = m_dec && (opd inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111});
    s2  = m_dec && (opd inside {4'b0001, 4'b0101}) && !c_ir[5];
    mm1 = s1 && dr == c_ir[8:6] && just_returned && op_is_load(opx);
    mm2 = s2 && dr == c_ir[2:0] && just_returned && op_is_load(opx);
    a1  = s1 && dr == c_ir[8:6] && op_is_alu(opx) && !mm1;
    a2  = s2 && dr == c_ir[2:0] && op_is_alu(opx) && !mm2;
    return {m_upc, m_fetch, m_dec, m_exe, m_wb, br, a1, a2, mm1, mm2, m_ms};
  endfunction

  task applyStimulus(input logic rst, input logic [15:0] ir, input logic [15:0] irx,
                     input logic [2:0] psr_v, input logic cd, input logic ci);
    @(posedge clock);
    model_step();
    #1;
    reset = rst;
    IR = ir;
    IR_Exec = irx;
    NZP = irx[11:9];
    psr = psr_v;
    complete_data = cd;
    complete_instr = ci;
    IMem_dout = 16'($urandom);
    c_rst = rst;
    c_ir = ir;
    c_irx = irx;
    c_psr = psr_v;
    c_cd = cd;
    c_ci = ci;
    if (!rst) model_reset();
    cycle++;
    exp_q.push_back(expected_now());
  endtask

  task checkOutput(input logic [11:0] want);
    logic [11:0] got;
    got = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
           br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL outputs cycle %0d: got %b required %b (upc,fetch,dec,exe,wb,br,a1,a2,m1,m2,ms)",
               cycle, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    logic [15:0] r_ir, r_irx;
    checks = 0;
    failures = 0;
    cycle = 0;
    reset = 1'b1;
    IR = NOP_D;
    IR_Exec = NOP_X;
    NZP = 3'b000;
    psr = 3'b010;
    complete_data = 1'b0;
    complete_instr = 1'b1;
    IMem_dout = 16'h0000;
    c_rst = 1'b0; c_ir = NOP_D; c_irx = NOP_X; c_psr = 3'b010; c_cd = 1'b0; c_ci = 1'b1;
    model_reset();
    #2 reset = 1'b0;

    // Reset, then fill sequence.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);

    // LDI R2 with two-step access, then a dependent ADD on the return cycle.
    applyStimulus(1'b1, NOP_D, 16'hA400, 3'b010, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b1, NOP_D, 16'hA400, 3'b010, (k == 2 || k == 5), 1'b1);
    applyStimulus(1'b1, 16'h1881, 16'hA400, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);

    // ALU forwarding: ADD R1,R2,R3 behind ADD R3,R0,#1.
    applyStimulus(1'b1, 16'h1283, 16'h1621, 3'b010, 1'b0, 1'b1);

    // BRz taken and not taken.
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 16'h0405, NOP_X, (p == 0) ? 3'b010 : 3'b100, 1'b0, 1'b1);
      applyStimulus(1'b1, NOP_D, 16'h0405, (p == 0) ? 3'b010 : 3'b100, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
        applyStimulus(1'b1, NOP_D, NOP_X, (p == 0) ? 3'b010 : 3'b100, 1'b0, 1'b1);
    end

    // STR in execute while a BR enters decode: bubble frozen across the stall.
    applyStimulus(1'b1, 16'h0E00, 16'h7280, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, 16'h7280, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, 16'h7280, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, 16'h7280, 3'b010, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);

    // Reset asserted while a LD access is pending.
    applyStimulus(1'b1, NOP_D, 16'h2A00, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, 16'h2A00, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b1, NOP_D, 16'h2A00, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b0, NOP_D, 16'h2A00, 3'b010, 1'b0, 1'b1);
    applyStimulus(1'b0, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, NOP_D, NOP_X, 3'b010, 1'b0, 1'b1);

    // Randomized traffic with narrow register fields so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      r_ir = 16'($urandom);
      r_ir[11:9] = 3'($urandom_range(0, 3));
      r_ir[8:6]  = 3'($urandom_range(0, 3));
      r_ir[2:0]  = 3'($urandom_range(0, 3));
      r_irx = 16'($urandom);
      r_irx[11:9] = 3'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) != 0), r_ir, r_irx, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
